// File: rtl/ball_bouncer.sv
// Per-pixel renderer for a square ball bouncing inside the visible area.
// Position advances once per frame on the vblank rising edge; RGB is registered (1 clk latency).
module ball_bouncer #(
    parameter int H_VISIBLE = 640,
    parameter int V_VISIBLE = 480,
    parameter int BALL_SIZE = 16,
    parameter int INIT_X    = 128,
    parameter int INIT_Y    = 128,
    parameter int SPEED_X   = 2,
    parameter int SPEED_Y   = 1
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [9:0] i_hpos,
    input  logic [9:0] i_vpos,
    input  logic       i_visible,
    input  logic       i_vblank,
    input  logic       i_enable,
    output logic [7:0] o_r,
    output logic [7:0] o_g,
    output logic [7:0] o_b,
    output logic       o_visible,
    output logic [9:0] o_ball_x,
    output logic [9:0] o_ball_y,
    output logic       o_bounce_x,
    output logic       o_bounce_y
);

    localparam logic [10:0] C_MAX_X   = 11'(H_VISIBLE - BALL_SIZE);
    localparam logic [10:0] C_MAX_Y   = 11'(V_VISIBLE - BALL_SIZE);
    localparam logic [10:0] C_SPD_X   = 11'(SPEED_X);
    localparam logic [10:0] C_SPD_Y   = 11'(SPEED_Y);
    localparam logic [10:0] C_SIZE_M1 = 11'(BALL_SIZE - 1);
    localparam logic [9:0]  C_INIT_X  = 10'(INIT_X);
    localparam logic [9:0]  C_INIT_Y  = 10'(INIT_Y);
    localparam logic [7:0]  C_FULL    = 8'hFF;
    localparam logic [7:0]  C_BG_BLUE = 8'h40;

    typedef struct packed {
        logic [9:0] pos;
        logic       dir_neg;
        logic       wall;
    } axis_t;

    // One axis of motion; 11-bit arithmetic so neither overshoot nor undershoot wraps.
    function automatic axis_t axis_step(
        input logic [9:0]  pos,
        input logic        dir_neg,
        input logic [10:0] speed,
        input logic [10:0] max_pos
    );
        logic [10:0] wide;
        logic [10:0] up;
        logic [10:0] dn;
        axis_t       res;
        wide        = {1'b0, pos};
        up          = wide + speed;
        dn          = wide - speed;
        res.pos     = pos;
        res.dir_neg = dir_neg;
        res.wall    = 1'b0;
        if (!dir_neg) begin
            if (up > max_pos) begin
                res.pos     = max_pos[9:0];
                res.dir_neg = 1'b1;
                res.wall    = 1'b1;
            end else begin
                res.pos = up[9:0];
            end
        end else begin
            if (wide < speed) begin
                res.pos     = 10'd0;
                res.dir_neg = 1'b0;
                res.wall    = 1'b1;
            end else begin
                res.pos = dn[9:0];
            end
        end
        return res;
    endfunction

    logic [9:0]  r_x;
    logic [9:0]  r_y;
    logic        r_dir_x_neg;
    logic        r_dir_y_neg;
    logic        r_vblank_q;
    logic        r_bounce_x;
    logic        r_bounce_y;
    logic [7:0]  r_r;
    logic [7:0]  r_g;
    logic [7:0]  r_b;
    logic        r_visible;

    logic        w_tick;
    axis_t       w_step_x;
    axis_t       w_step_y;
    logic [10:0] w_x_end;
    logic [10:0] w_y_end;
    logic        w_in_x;
    logic        w_in_y;
    logic        w_hit;

    assign w_tick   = i_vblank & ~r_vblank_q & i_enable;
    assign w_step_x = axis_step(r_x, r_dir_x_neg, C_SPD_X, C_MAX_X);
    assign w_step_y = axis_step(r_y, r_dir_y_neg, C_SPD_Y, C_MAX_Y);

    assign w_x_end = {1'b0, r_x} + C_SIZE_M1;
    assign w_y_end = {1'b0, r_y} + C_SIZE_M1;
    assign w_in_x  = (i_hpos >= r_x) & ({1'b0, i_hpos} <= w_x_end);
    assign w_in_y  = (i_vpos >= r_y) & ({1'b0, i_vpos} <= w_y_end);
    assign w_hit   = i_visible & w_in_x & w_in_y;

    // Ball motion: reset overrides a coincident tick; pulses last one clk after a tick.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_x         <= C_INIT_X;
            r_y         <= C_INIT_Y;
            r_dir_x_neg <= 1'b0;
            r_dir_y_neg <= 1'b0;
            r_vblank_q  <= 1'b1;
            r_bounce_x  <= 1'b0;
            r_bounce_y  <= 1'b0;
        end else begin
            r_vblank_q <= i_vblank;
            if (w_tick) begin
                r_x         <= w_step_x.pos;
                r_dir_x_neg <= w_step_x.dir_neg;
                r_bounce_x  <= w_step_x.wall;
                r_y         <= w_step_y.pos;
                r_dir_y_neg <= w_step_y.dir_neg;
                r_bounce_y  <= w_step_y.wall;
            end else begin
                r_bounce_x <= 1'b0;
                r_bounce_y <= 1'b0;
            end
        end
    end

    // Pixel colour pipeline stage.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_r       <= 8'h00;
            r_g       <= 8'h00;
            r_b       <= 8'h00;
            r_visible <= 1'b0;
        end else begin
            r_visible <= i_visible;
            if (w_hit) begin
                r_r <= C_FULL;
                r_g <= C_FULL;
                r_b <= C_FULL;
            end else if (i_visible) begin
                r_r <= 8'h00;
                r_g <= 8'h00;
                r_b <= C_BG_BLUE;
            end else begin
                r_r <= 8'h00;
                r_g <= 8'h00;
                r_b <= 8'h00;
            end
        end
    end

    assign o_r        = r_r;
    assign o_g        = r_g;
    assign o_b        = r_b;
    assign o_visible  = r_visible;
    assign o_ball_x   = r_x;
    assign o_ball_y   = r_y;
    assign o_bounce_x = r_bounce_x;
    assign o_bounce_y = r_bounce_y;

endmodule
